// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steps the external pc register, fetches words over a
// req/ready memory handshake and hands them to decode, absorbing branch/jump redirects.
module fetch_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                INC      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic [ADDR_W-1:0] pc_next,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [ADDR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      OUT   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

   state_t            state;
   logic [ADDR_W-1:0] flush_addr;

   // The pc register has no reset of its own, so reset must act on pc_next and the
   // memory request immediately rather than waiting for a clock edge.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_cur;
      pc_next   = pc_cur;
      if (!rst_n) begin
         imem_addr = RESET_PC;
         pc_next   = RESET_PC;
      end else begin
         imem_req = (state != OUT);
         if (state == FLUSH)
            imem_addr = flush_addr;
         if (redirect)
            pc_next = redirect_pc;
         else if (state == FETCH && imem_ready)
            pc_next = pc_cur + INC_W;
      end
   end

   // A redirect during a stalled fetch parks the old address in flush_addr so the
   // request stays stable until memory answers and the stale word is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         flush_addr  <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  instr_valid <= 1'b0;
                  if (!imem_ready) begin
                     flush_addr <= pc_cur;
                     state      <= FLUSH;
                  end
               end else if (imem_ready) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= OUT;
               end
            end
            OUT: begin
               if (redirect || instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            FLUSH: begin
               if (redirect)
                  instr_valid <= 1'b0;
               if (imem_ready)
                  state <= FETCH;
            end
            default: begin
               instr_valid <= 1'b0;
               state       <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: models the pc register and a transaction-level
// view of the fetch pipeline (held word queue, stale request), then runs directed and random cycles.
module tb_fetch_ctrl;

   localparam int          ADDR_W   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_cur;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] m_pc;
   logic [31:0] m_held[$];
   logic        m_stale;
   logic [31:0] m_stale_addr;
   logic [31:0] m_instr;

   fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .INC(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_cur      (pc_cur),
      .pc_next     (pc_next),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The external pc register: no enable, no reset.
   always_ff @(posedge clk) pc_cur <= pc_next;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_pc    = RESET_PC;
      m_held.delete();
      m_stale = 1'b0;
      m_stale_addr = '0;
      m_instr = '0;
   endtask

   task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic irdy,
                                input logic redir, input logic [31:0] rpc);
      imem_ready  = rdy;
      imem_rdata  = rdata;
      instr_ready = irdy;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
   endtask

   // Compares this cycle's outputs with the model, advances the model, then moves to the next negedge.
   task automatic checkOutput(input string tag);
      logic        exp_req;
      logic [31:0] exp_next;
      exp_req = (m_held.size() == 0);
      if (redirect)
         exp_next = redirect_pc;
      else if (exp_req && !m_stale && imem_ready)
         exp_next = m_pc + 32'd4;
      else
         exp_next = m_pc;
      chk({tag, ".pc_cur"}, pc_cur, m_pc);
      chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req)
         chk({tag, ".imem_addr"}, imem_addr, m_stale ? m_stale_addr : m_pc);
      chk({tag, ".pc_next"}, pc_next, exp_next);
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, !exp_req});
      chk({tag, ".instr"}, instr, m_instr);
      if (!exp_req) begin
         if (redirect || instr_ready)
            void'(m_held.pop_front());
      end else if (imem_ready) begin
         if (m_stale)
            m_stale = 1'b0;
         else if (!redirect) begin
            m_held.push_back(imem_rdata);
            m_instr = imem_rdata;
         end
      end else if (redirect && !m_stale) begin
         m_stale      = 1'b1;
         m_stale_addr = m_pc;
      end
      m_pc = exp_next;
      @(negedge clk);
   endtask

   task automatic runCycle(input string tag, input logic rdy, input logic [31:0] rdata,
                           input logic irdy, input logic redir, input logic [31:0] rpc);
      applyStimulus(rdy, rdata, irdy, redir, rpc);
      checkOutput(tag);
   endtask

   // Drops rst_n between clock edges and checks the outputs react without an edge.
   task automatic doAsyncReset(input string tag);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, ".pc_next"}, pc_next, RESET_PC);
      chk({tag, ".imem_addr"}, imem_addr, RESET_PC);
      chk({tag, ".instr"}, instr, 32'd0);
      @(posedge clk);
      @(negedge clk);
      modelReset();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] rpc;
      rst_n = 1'b0;
      imem_ready = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.imem_req", {31'd0, imem_req}, 32'd0);
      chk("reset.instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("reset.instr", instr, 32'd0);
      chk("reset.pc_next", pc_next, RESET_PC);
      chk("reset.imem_addr", imem_addr, RESET_PC);
      chk("reset.pc_cur", pc_cur, RESET_PC);
      rst_n = 1'b1;

      // Back-to-back fetches at 0x0 and 0x4.
      runCycle("f0",   1'b1, 32'hA000_0000, 1'b1, 1'b0, 32'h0);
      runCycle("o0",   1'b1, 32'h0,         1'b1, 1'b0, 32'h0);
      runCycle("f4",   1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h0);
      runCycle("o4",   1'b1, 32'h0,         1'b1, 1'b0, 32'h0);
      // Memory stalls three cycles at 0x8, then decode stalls four cycles.
      for (int i = 0; i < 3; i++) runCycle("wait8", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      runCycle("f8",   1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) runCycle("hold8", 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0);
      runCycle("o8",   1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      // Redirect to 0x100 while a fetch at 0xC is stalled; stale word arrives later.
      runCycle("rdrC", 1'b0, 32'h0,         1'b1, 1'b1, 32'h100);
      runCycle("flC",  1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
      runCycle("drpC", 1'b1, 32'hBAD0_000C, 1'b1, 1'b0, 32'h0);
      runCycle("f100", 1'b1, 32'hA000_0100, 1'b1, 1'b0, 32'h0);
      runCycle("o100", 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
      // Redirect coinciding with imem_ready: the word is dropped.
      runCycle("r200", 1'b1, 32'hBAD0_0104, 1'b1, 1'b1, 32'h200);
      // Two redirects during a flush: the second target wins.
      runCycle("r300", 1'b0, 32'h0,         1'b1, 1'b1, 32'h300);
      runCycle("r400", 1'b0, 32'h0,         1'b1, 1'b1, 32'h400);
      runCycle("dr200",1'b1, 32'hBAD0_0200, 1'b1, 1'b0, 32'h0);
      runCycle("f400", 1'b1, 32'hA000_0400, 1'b0, 1'b0, 32'h0);
      // Redirect while the word is offered and accepted in the same cycle.
      runCycle("oRdr", 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC);
      // PC wrap from 0xFFFF_FFFC to 0.
      runCycle("fTop", 1'b1, 32'hA0FF_FFFC, 1'b1, 1'b0, 32'h0);
      runCycle("oTop", 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
      runCycle("wait0",1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
      doAsyncReset("arst1");
      runCycle("fRst", 1'b1, 32'hA000_1000, 1'b1, 1'b0, 32'h0);
      runCycle("oRst", 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);

      // Randomized traffic against the model, with one reset in the middle.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) doAsyncReset("arst2");
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
         runCycle("rand", $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 15, rpc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
